x2_delay_line: RTL and testbench
================================

// Module: x2_delay_line
// PURPOSE
//  Programmable sample-delay generator for the correlation path. Buffers the x2 bit stream in a ring buffer.
//  Presents x2 delayed by D samples and by D+1 samples, plus x1 aligned to the same sample strobe.
//  These three outputs drive the correlation detector's x1_k, x2_k_delayed and x2_k_delayed_minus_1 inputs.
//  D is loaded over a req/ack handshake and can optionally self-track from the detector's sign output.
// PARAMETERS
//  AW          6    ring address width; DEPTH = 2**AW samples; MAX_D = DEPTH-2
//  DEF_DELAY   0    D value after reset (must be <= MAX_D)
//  TRACK_LOG2  8    tracking update period = 2**TRACK_LOG2 sample strobes (DELAY_TRACK_EN only)
// PORTS
//  clk                   in   1   system clock, all logic on rising edge
//  rst                   in   1   synchronous, active-low reset
//  sample_en             in   1   sample strobe; one new x1/x2 sample per high cycle
//  x1_in                 in   1   reference stream sample
//  x2_in                 in   1   stream to be delayed
//  delay_in              in   AW  requested delay D
//  delay_load            in   1   load request for delay_in
//  delay_ack             out  1   1-cycle pulse: delay_in accepted
//  delay_cur             out  AW  D currently applied
//  corr_sign             in   1   detector MSB (1 = x2 lags, increase D); ignored unless DELAY_TRACK_EN
//  x1_k                  out  1   x1[n]
//  x2_k_delayed          out  1   x2[n-D]
//  x2_k_delayed_minus_1  out  1   x2[n-D-1]
//  out_valid             out  1   1-cycle pulse, one cycle after each sample_en
//  primed                out  1   level: enough history for current D
// BEHAVIOUR
//  - Reset (rst==0 at edge): wptr=0, fill=0, delay_cur=DEF_DELAY, all outputs 0; buffer RAM not cleared.
//  - Strobe n (sample_en=1): x2_in written at wptr; wptr+1 mod DEPTH; fill+1 saturating at DEPTH.
//  - Registered outputs update on the strobe edge, so latency is 1 cycle; out_valid pulses the same cycle.
//  - Read taps: wptr-D and wptr-D-1 mod DEPTH. For D=0, x2_k_delayed bypasses to x2_in.
//  - Outputs hold between strobes.
//  - primed = (fill >= D+2), evaluated with the D used for that strobe.
//  - While primed==0, x2_k_delayed and x2_k_delayed_minus_1 are forced 0; x1_k always passes.
//  - delay_load: sampled every cycle; delay_cur <= min(delay_in, MAX_D); delay_ack pulses the next cycle.
//  - A load does not clear fill, so primed re-evaluates against the new D.
//  - delay_load and sample_en in the same cycle: that strobe uses the old D; the new D applies from the next strobe.
//  - Back-to-back loads: each is accepted and acked; the last one wins.
//  - Pointer wrap at DEPTH-1 -> 0 is seamless; the output sequence is unaffected.
//  - Reset mid-stream: history is discarded; primed=0 until D+2 new strobes.
// CONFIGURATION
//  DELAY_TRACK_EN defined:
//   - Counter tcnt counts strobes; on wrap of 2**TRACK_LOG2, D <= D+1 if corr_sign else D-1.
//   - D saturates at 0 and MAX_D.
//   - A delay_load in the same cycle takes priority over tracking.
//   - delay_load resets tcnt.
//   - Tracking never pulses delay_ack.
//  DELAY_TRACK_EN undefined: no tcnt; corr_sign unused; D changes only via delay_load.
// STRUCTURE
//  - ccd_pkg: AW default, DEPTH and MAX_D derivation, tracking-step constants.
//  - Sub-module bit_ring_buffer: DEPTH x 1 RAM, one write port, two read ports (taps).
//  - Top holds pointers, fill counter, D register, handshake and tracking logic.
// TESTING
//  - Reset then D=3, drive 0,1,1,0,1,0,0,1: primed rises after the 5th strobe.
//    On the 8th strobe, delayed=x2[4]=1 and minus_1=x2[3]=0.
//  - D=0: x2_k_delayed equals x2_in on every strobe; minus_1 equals the previous x2_in.
//  - delay_in=63 with AW=6: delay_cur=62, delay_ack pulses once, primed=0 until fill>=64.
//  - delay_load with sample_en on the same cycle (D 2->5): that strobe uses D=2; the next uses D=5.
//  - 200 strobes of a PRBS with D=10: outputs match the reference model across two pointer wraps.
//    Asserting rst at strobe 150 drops primed and zeros all outputs.
//  - DELAY_TRACK_EN, TRACK_LOG2=2, corr_sign=1, D=61: D steps to 62 after 4 strobes, then holds at 62.

Source files
------------

// File: rtl/ccd_pkg.sv
// Shared constants for the correlation-path delay line: default ring size,
// depth / maximum-delay derivation and the tracking step directions.
package ccd_pkg;

    localparam int CCD_AW = 6;

    // Tracking moves D by one sample per update period.
    localparam int TRK_STEP_UP   = 1;
    localparam int TRK_STEP_DOWN = 1;

    function automatic int ccd_depth(input int aw);
        return 1 << aw;
    endfunction

    // Two slots stay in reserve so that both taps (D and D+1) always point
    // at history that has not yet been overwritten.
    function automatic int ccd_max_d(input int aw);
        return (1 << aw) - 2;
    endfunction

endpackage

// File: rtl/bit_ring_buffer.sv
// DEPTH x 1 sample store: one synchronous write port and two
// combinational read taps. Contents are not reset.
module bit_ring_buffer
    import ccd_pkg::*;
#(
    parameter int AW = CCD_AW
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic          wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    output logic          rdata_a_o,
    output logic          rdata_b_o
);

    localparam int DEPTH = ccd_depth(AW);

    logic [DEPTH-1:0] mem_q;

    // Write the incoming sample on a strobe.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/x2_delay_line.sv
// Programmable sample-delay generator feeding the correlation detector.
// Optional build macro DELAY_TRACK_EN: lets D follow corr_sign by one step
// every 2**TRACK_LOG2 strobes. Without it, D changes only via delay_load.
module x2_delay_line
    import ccd_pkg::*;
#(
    parameter int AW         = CCD_AW,
    parameter int DEF_DELAY  = 0,
    parameter int TRACK_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic          x1_in,
    input  logic          x2_in,
    input  logic [AW-1:0] delay_in,
    input  logic          delay_load,
    output logic          delay_ack,
    output logic [AW-1:0] delay_cur,
    input  logic          corr_sign,
    output logic          x1_k,
    output logic          x2_k_delayed,
    output logic          x2_k_delayed_minus_1,
    output logic          out_valid,
    output logic          primed
);

    localparam logic [AW-1:0] MAX_D_V = AW'(ccd_max_d(AW));
    localparam logic [AW-1:0] DEF_D_V = AW'(DEF_DELAY);
    localparam logic [AW:0]   FULL_V  = (AW+1)'(ccd_depth(AW));
    localparam logic [AW:0]   TWO_V   = (AW+1)'(2);

    logic [AW-1:0] wptr_q;
    logic [AW:0]   fill_q, fill_d;
    logic [AW-1:0] delay_q, delay_d, load_val;
    logic          ack_q, valid_q, primed_q;
    logic          x1_q, xd_q, xdm1_q;
    logic          primed_strobe, primed_load;
    logic          tap_a, tap_b;
    logic [AW-1:0] raddr_a, raddr_b;

    assign raddr_a = wptr_q - delay_q;
    assign raddr_b = wptr_q - delay_q - 1'b1;

    bit_ring_buffer #(.AW(AW)) u_ring (
        .clk       (clk),
        .we_i      (sample_en),
        .waddr_i   (wptr_q),
        .wdata_i   (x2_in),
        .raddr_a_i (raddr_a),
        .raddr_b_i (raddr_b),
        .rdata_a_o (tap_a),
        .rdata_b_o (tap_b)
    );

    // Fill accounting and priming decisions for a strobe and for a bare load.
    always_comb begin
        fill_d        = (fill_q == FULL_V) ? fill_q : fill_q + 1'b1;
        primed_strobe = fill_d >= ({1'b0, delay_q} + TWO_V);
        load_val      = (delay_in > MAX_D_V) ? MAX_D_V : delay_in;
        primed_load   = fill_q >= ({1'b0, load_val} + TWO_V);
    end

`ifdef DELAY_TRACK_EN
    logic [TRACK_LOG2-1:0] tcnt_q, tcnt_d;

    // Next D: an explicit load wins; otherwise step toward corr_sign when the
    // strobe down-counter reaches terminal count.
    always_comb begin
        delay_d = delay_q;
        tcnt_d  = tcnt_q;
        if (delay_load) begin
            delay_d = load_val;
            tcnt_d  = '1;
        end else if (sample_en) begin
            if (tcnt_q == '0) begin
                tcnt_d = '1;
                if (corr_sign && (delay_q != MAX_D_V)) begin
                    delay_d = delay_q + AW'(TRK_STEP_UP);
                end else if (!corr_sign && (delay_q != '0)) begin
                    delay_d = delay_q - AW'(TRK_STEP_DOWN);
                end
            end else begin
                tcnt_d = tcnt_q - 1'b1;
            end
        end
    end

    // Tracking period counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tcnt_q <= '1;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end
`else
    logic unused_track;
    assign unused_track = corr_sign & (TRACK_LOG2 > 0);

    // Next D: only an explicit load changes it.
    always_comb begin
        delay_d = delay_q;
        if (delay_load) begin
            delay_d = load_val;
        end
    end
`endif

    // Pointer, fill, D register, handshake and registered taps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q   <= '0;
            fill_q   <= '0;
            delay_q  <= DEF_D_V;
            ack_q    <= 1'b0;
            valid_q  <= 1'b0;
            primed_q <= 1'b0;
            x1_q     <= 1'b0;
            xd_q     <= 1'b0;
            xdm1_q   <= 1'b0;
        end else begin
            delay_q <= delay_d;
            ack_q   <= delay_load;
            valid_q <= sample_en;
            if (sample_en) begin
                wptr_q   <= wptr_q + 1'b1;
                fill_q   <= fill_d;
                primed_q <= primed_strobe;
                x1_q     <= x1_in;
                // D=0 reads the sample being written this very cycle.
                xd_q     <= primed_strobe & ((delay_q == '0) ? x2_in : tap_a);
                xdm1_q   <= primed_strobe & tap_b;
            end else if (delay_load) begin
                // A new D without a strobe may un-prime the held taps.
                primed_q <= primed_load;
                xd_q     <= xd_q & primed_load;
                xdm1_q   <= xdm1_q & primed_load;
            end
        end
    end

    assign delay_ack            = ack_q;
    assign delay_cur            = delay_q;
    assign out_valid            = valid_q;
    assign primed               = primed_q;
    assign x1_k                 = x1_q;
    assign x2_k_delayed         = xd_q;
    assign x2_k_delayed_minus_1 = xdm1_q;

endmodule

// File: tb/tb_x2_delay_line.sv
// Bench for x2_delay_line: randomized streams checked against a history-queue
// model of the delayed taps (AW=6, DEF_DELAY=0, TRACK_LOG2=2).
module tb_x2_delay_line;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sample_en = 1'b0;
    logic       x1_in = 1'b0;
    logic       x2_in = 1'b0;
    logic [5:0] delay_in = '0;
    logic       delay_load = 1'b0;
    logic       delay_ack;
    logic [5:0] delay_cur;
    logic       corr_sign = 1'b0;
    logic       x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed;

    int errors = 0;
    int checks = 0;

    // Reference model state: full x2 history since reset, current D.
    bit   m_hist[$];
    int   m_d  = 0;
    int   m_tc = 0;
    logic exp_x1, exp_xd, exp_xm1, exp_primed;

    x2_delay_line #(.AW(6), .DEF_DELAY(0), .TRACK_LOG2(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .sample_en            (sample_en),
        .x1_in                (x1_in),
        .x2_in                (x2_in),
        .delay_in             (delay_in),
        .delay_load           (delay_load),
        .delay_ack            (delay_ack),
        .delay_cur            (delay_cur),
        .corr_sign            (corr_sign),
        .x1_k                 (x1_k),
        .x2_k_delayed         (x2_k_delayed),
        .x2_k_delayed_minus_1 (x2_k_delayed_minus_1),
        .out_valid            (out_valid),
        .primed               (primed)
    );

    always #5 clk = ~clk;

    function automatic int clamp_d(input logic [5:0] d);
        return (int'(d) > 62) ? 62 : int'(d);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; sample_en = 1'b0; delay_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        m_hist.delete();
        m_d = 0; m_tc = 0;
        exp_x1 = 0; exp_xd = 0; exp_xm1 = 0; exp_primed = 0;
    endtask

    task automatic do_load(input logic [5:0] din);
        @(negedge clk);
        delay_load = 1'b1; delay_in = din;
        m_d = clamp_d(din); m_tc = 0;
        exp_primed = ((m_hist.size() > 64) ? 64 : m_hist.size()) >= m_d + 2;
        if (!exp_primed) begin exp_xd = 0; exp_xm1 = 0; end
        @(posedge clk); #1;
        delay_load = 1'b0;
    endtask

    task automatic do_strobe(input logic x1, input logic x2, input logic ld, input logic [5:0] din);
        int n;
        @(negedge clk);
        sample_en = 1'b1; x1_in = x1; x2_in = x2; delay_load = ld; delay_in = din;
        m_hist.push_back(x2);
        n = m_hist.size() - 1;
        exp_x1 = x1;
        exp_primed = (n + 1) >= (m_d + 2);
        exp_xd = 1'b0; exp_xm1 = 1'b0;
        if (exp_primed) begin
            exp_xd  = m_hist[n - m_d];
            exp_xm1 = m_hist[n - m_d - 1];
        end
        if (ld) begin
            m_d = clamp_d(din); m_tc = 0;
        end
`ifdef DELAY_TRACK_EN
        else begin
            m_tc++;
            if (m_tc == 4) begin
                m_tc = 0;
                if (corr_sign) m_d = (m_d < 62) ? m_d + 1 : 62;
                else           m_d = (m_d > 0) ? m_d - 1 : 0;
            end
        end
`endif
        @(posedge clk); #1;
        sample_en = 1'b0; delay_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        checks++;
        if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed, delay_ack} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed, delay_ack});
        end
        checks++;
        if (delay_cur !== 6'd0) begin
            errors++;
            $display("FAIL reset_delay_cur: got %0d want 0", delay_cur);
        end
    endtask

    task automatic test_d3_sequence();
        logic [7:0] seq = 8'b1001_0110; // bit i = strobe i: 0,1,1,0,1,0,0,1
        do_reset();
        do_load(6'd3);
        checks++;
        if (delay_ack !== 1'b1 || delay_cur !== 6'd3) begin
            errors++;
            $display("FAIL d3_load: ack=%b cur=%0d want ack=1 cur=3", delay_ack, delay_cur);
        end
        for (int i = 0; i < 8; i++) begin
            do_strobe(1'($urandom), seq[i], 1'b0, 6'd0);
            checks++;
            if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed} !==
                {exp_x1, exp_xd, exp_xm1, 1'b1, exp_primed}) begin
                errors++;
                $display("FAIL d3_strobe%0d: got %b want %b", i,
                         {x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed},
                         {exp_x1, exp_xd, exp_xm1, 1'b1, exp_primed});
            end
`ifndef DELAY_TRACK_EN
            if (i == 3 || i == 4) begin
                checks++;
                if (primed !== (i == 4)) begin
                    errors++;
                    $display("FAIL d3_primed_edge%0d: got %b want %b", i, primed, (i == 4));
                end
            end
            if (i == 7) begin
                checks++;
                if ({x2_k_delayed, x2_k_delayed_minus_1} !== 2'b10) begin
                    errors++;
                    $display("FAIL d3_eighth: got %b want 10", {x2_k_delayed, x2_k_delayed_minus_1});
                end
            end
`endif
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, delay_ack, x2_k_delayed, x2_k_delayed_minus_1, primed} !==
            {1'b0, 1'b0, exp_xd, exp_xm1, exp_primed}) begin
            errors++;
            $display("FAIL d3_hold: got %b want %b",
                     {out_valid, delay_ack, x2_k_delayed, x2_k_delayed_minus_1, primed},
                     {1'b0, 1'b0, exp_xd, exp_xm1, exp_primed});
        end
    endtask

    task automatic test_d0_bypass();
        logic x2, prev;
        do_reset();
        do_load(6'd0);
        prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            x2 = 1'($urandom);
            do_strobe(1'($urandom), x2, 1'b0, 6'd0);
            checks++;
            if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed} !== {exp_x1, exp_xd, exp_xm1, exp_primed}) begin
                errors++;
                $display("FAIL d0_model%0d: got %b want %b", i,
                         {x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed},
                         {exp_x1, exp_xd, exp_xm1, exp_primed});
            end
`ifndef DELAY_TRACK_EN
            if (i >= 1) begin
                checks++;
                if ({x2_k_delayed, x2_k_delayed_minus_1} !== {x2, prev}) begin
                    errors++;
                    $display("FAIL d0_bypass%0d: got %b want %b", i,
                             {x2_k_delayed, x2_k_delayed_minus_1}, {x2, prev});
                end
            end
`endif
            prev = x2;
        end
    endtask

    task automatic test_clamp();
        do_reset();
        do_load(6'd63);
        checks++;
        if (delay_ack !== 1'b1 || delay_cur !== 6'd62) begin
            errors++;
            $display("FAIL clamp_load: ack=%b cur=%0d want ack=1 cur=62", delay_ack, delay_cur);
        end
        @(posedge clk); #1;
        checks++;
        if (delay_ack !== 1'b0) begin
            errors++;
            $display("FAIL clamp_ack_once: got %b want 0", delay_ack);
        end
        for (int i = 0; i < 70; i++) begin
            do_strobe(1'($urandom), 1'($urandom), 1'b0, 6'd0);
            checks++;
            if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed} !== {exp_x1, exp_xd, exp_xm1, exp_primed}) begin
                errors++;
                $display("FAIL clamp_strobe%0d: got %b want %b", i,
                         {x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed},
                         {exp_x1, exp_xd, exp_xm1, exp_primed});
            end
`ifndef DELAY_TRACK_EN
            if (i == 62 || i == 63) begin
                checks++;
                if (primed !== (i == 63)) begin
                    errors++;
                    $display("FAIL clamp_primed%0d: got %b want %b", i, primed, (i == 63));
                end
            end
`endif
        end
    endtask

    task automatic test_load_with_strobe();
        do_reset();
        do_load(6'd2);
        for (int i = 0; i < 8; i++) do_strobe(1'($urandom), 1'($urandom), 1'b0, 6'd0);
        for (int i = 0; i < 4; i++) begin
            do_strobe(1'($urandom), 1'($urandom), (i == 0), 6'd5);
            checks++;
            if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed} !== {exp_x1, exp_xd, exp_xm1, exp_primed}) begin
                errors++;
                $display("FAIL same_cycle%0d: got %b want %b", i,
                         {x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed},
                         {exp_x1, exp_xd, exp_xm1, exp_primed});
            end
            if (i == 0) begin
                checks++;
                if (delay_ack !== 1'b1 || delay_cur !== 6'd5) begin
                    errors++;
                    $display("FAIL same_cycle_ack: ack=%b cur=%0d want ack=1 cur=5", delay_ack, delay_cur);
                end
            end
        end
    endtask

    task automatic test_prbs_wrap_reset();
        logic [6:0] lfsr;
        lfsr = 7'($urandom_range(1, 127));
        do_reset();
        do_load(6'd10);
        for (int i = 0; i < 200; i++) begin
            if (i == 150) begin
                do_reset();
                checks++;
                if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed} !== 5'b0) begin
                    errors++;
                    $display("FAIL prbs_reset: got %b want 00000",
                             {x1_k, x2_k_delayed, x2_k_delayed_minus_1, out_valid, primed});
                end
                do_load(6'd10);
            end
            lfsr = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            do_strobe(1'($urandom), lfsr[6], 1'b0, 6'd0);
            checks++;
            if ({x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed} !== {exp_x1, exp_xd, exp_xm1, exp_primed}) begin
                errors++;
                $display("FAIL prbs_strobe%0d: got %b want %b", i,
                         {x1_k, x2_k_delayed, x2_k_delayed_minus_1, primed},
                         {exp_x1, exp_xd, exp_xm1, exp_primed});
            end
        end
    endtask

`ifdef DELAY_TRACK_EN
    task automatic test_track();
        do_reset();
        corr_sign = 1'b1;
        do_load(6'd61);
        for (int i = 0; i < 12; i++) begin
            do_strobe(1'($urandom), 1'($urandom), 1'b0, 6'd0);
            checks++;
            if (delay_cur !== 6'(m_d) || delay_ack !== 1'b0) begin
                errors++;
                $display("FAIL track%0d: cur=%0d ack=%b want cur=%0d ack=0", i, delay_cur, delay_ack, m_d);
            end
            if (i == 2 || i == 3 || i == 11) begin
                checks++;
                if (delay_cur !== ((i == 2) ? 6'd61 : 6'd62)) begin
                    errors++;
                    $display("FAIL track_step%0d: got %0d want %0d", i, delay_cur, (i == 2) ? 61 : 62);
                end
            end
        end
        corr_sign = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_d3_sequence();
        test_d0_bypass();
        test_clamp();
        test_load_with_strobe();
        test_prbs_wrap_reset();
`ifdef DELAY_TRACK_EN
        test_track();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
